decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_pkg.sv | 32 +++
 rtl/rv32_decoder.sv | 98 +++++++++
 rtl/decode_stage.sv | 52 +++++
 tb/tb_decode_stage.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// decode_pkg: shared decode packet, functional-unit and occupancy types, RV32I opcodes
package decode_pkg;
  typedef enum logic [1:0] {FU_ALU, FU_BR, FU_LSU, FU_MULDIV} fu_type_t;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_state_t;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        rd_we;
    logic        use_rs1;
    logic        use_rs2;
    fu_type_t    fu_type;
    logic        illegal;
  } decode_pkt_t;
endpackage

// File: rtl/rv32_decoder.sv
// rv32_decoder: combinational RV32I decode of one instruction into decode_pkt_t
// DECODE_RVM_EN: when defined, OP with funct7=0000001 decodes as MUL/DIV
module rv32_decoder
  import decode_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] inst,
  output decode_pkt_t pkt
);
  logic [2:0] f3;
  logic [6:0] f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic legal, wr;
  assign f3 = inst[14:12];
  assign f7 = inst[31:25];
  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'h0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  always_comb begin
    pkt = '0;
    legal = 1'b1;
    wr = 1'b1;
    pkt.pc = pc;
    pkt.inst = inst;
    pkt.opcode = inst[6:0];
    pkt.funct3 = f3;
    pkt.funct7 = f7;
    pkt.rd = inst[11:7];
    pkt.rs1 = inst[19:15];
    pkt.rs2 = inst[24:20];
    pkt.fu_type = FU_ALU;
    case (inst[6:0])
      OPC_LUI, OPC_AUIPC: pkt.imm = imm_u;
      OPC_JAL: begin
        pkt.imm = imm_j;
        pkt.fu_type = FU_BR;
      end
      OPC_JALR: begin
        pkt.imm = imm_i;
        pkt.use_rs1 = 1'b1;
        pkt.fu_type = FU_BR;
        legal = f3 == 3'b000;
      end
      OPC_BRANCH: begin
        pkt.imm = imm_b;
        pkt.use_rs1 = 1'b1;
        pkt.use_rs2 = 1'b1;
        pkt.fu_type = FU_BR;
        wr = 1'b0;
        legal = f3[2:1] != 2'b01;
      end
      OPC_LOAD: begin
        pkt.imm = imm_i;
        pkt.use_rs1 = 1'b1;
        pkt.fu_type = FU_LSU;
        legal = f3[1:0] != 2'b11 && f3 != 3'b110;
      end
      OPC_STORE: begin
        pkt.imm = imm_s;
        pkt.use_rs1 = 1'b1;
        pkt.use_rs2 = 1'b1;
        pkt.fu_type = FU_LSU;
        wr = 1'b0;
        legal = f3 < 3'd3;
      end
      OPC_OPIMM: begin
        pkt.imm = imm_i;
        pkt.use_rs1 = 1'b1;
        legal = f3 == 3'b001 ? f7 == 7'h00 : f3 == 3'b101 ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
      end
      OPC_OP: begin
        pkt.use_rs1 = 1'b1;
        pkt.use_rs2 = 1'b1;
`ifdef DECODE_RVM_EN
        pkt.fu_type = f7 == 7'h01 ? FU_MULDIV : FU_ALU;
        legal = f7 == 7'h00 || f7 == 7'h01 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
`else
        legal = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
`endif
      end
      OPC_FENCE: begin
        wr = 1'b0;
        legal = f3 == 3'b000;
      end
      OPC_SYSTEM: begin
        // only ECALL / EBREAK; CSR accesses are outside RV32I
        wr = 1'b0;
        legal = inst[31:21] == 11'h0 && inst[19:7] == 13'h0;
      end
      default: legal = 1'b0;
    endcase
    pkt.illegal = ~legal;
    pkt.rd_we = legal & wr & (inst[11:7] != 5'd0);
    if (!legal) pkt.fu_type = FU_ALU;
  end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: pops the fetch queue, decodes, and holds results in a 2-entry skid buffer
// DECODE_RVM_EN: forwarded to rv32_decoder to enable MUL/DIV decode
module decode_stage
  import decode_pkg::*;
#(
  parameter int IQ_WIDTH  = 64,
  parameter int OUT_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                iq_is_empty,
  input  logic [IQ_WIDTH-1:0] iq_rdata,
  output logic                iq_dequeue,
  input  logic                flush,
  output logic                dec_valid,
  input  logic                dec_ready,
  output decode_pkt_t         dec_pkt
);
  occ_state_t state_q, state_d;
  decode_pkt_t dec, slot0, slot1;
  logic push, pop, wr0, wr1;
  rv32_decoder u_dec (
    .pc  (iq_rdata[IQ_WIDTH-1 -: 32]),
    .inst(iq_rdata[31:0]),
    .pkt (dec)
  );
  // gated by rst_n so nothing is popped while reset is held
  assign iq_dequeue = rst_n & ~iq_is_empty & ~flush & (int'(state_q) < OUT_DEPTH);
  assign push = iq_dequeue;
  assign dec_valid = state_q != EMPTY;
  assign pop = dec_valid & dec_ready;
  assign dec_pkt = slot0;
  assign wr0 = (pop & (state_q == TWO | push)) | (push & state_q == EMPTY);
  assign wr1 = push & ~pop & state_q == ONE;
  always_comb begin
    state_d = flush ? EMPTY :
              push == pop ? state_q :
              push ? (state_q == EMPTY ? ONE : TWO) :
              (state_q == TWO ? ONE : EMPTY);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      state_q <= state_d;
      if (wr0) slot0 <= state_q == TWO ? slot1 : dec;
      if (wr1) slot1 <= dec;
    end
  end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: randomized self-checking bench for decode_stage against a queue-based reference
module tb_decode_stage;
  import decode_pkg::*;
  logic clk = 0, rst_n = 0, iq_is_empty = 1, flush = 0, dec_ready = 0;
  logic [63:0] iq_rdata = '0;
  logic iq_dequeue, dec_valid;
  decode_pkt_t dec_pkt;
  logic [63:0] iq_q[$];
  logic [63:0] buf_q[$];
  bit obs_dq, exp_dq;
  int n_chk = 0, n_pass = 0;
  decode_pkt_t e;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .iq_is_empty(iq_is_empty), .iq_rdata(iq_rdata),
    .iq_dequeue(iq_dequeue), .flush(flush), .dec_valid(dec_valid),
    .dec_ready(dec_ready), .dec_pkt(dec_pkt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] sext(logic [31:0] v, int n);
    return v[n-1] ? v - (32'd1 << n) : v;
  endfunction

  function automatic decode_pkt_t ref_decode(logic [63:0] ent);
    decode_pkt_t p = '0;
    logic [31:0] i = ent[31:0];
    logic [6:0] op = i[6:0];
    logic [2:0] f3 = i[14:12];
    logic [6:0] f7 = i[31:25];
    bit legal = 0, w = 0;
    fu_type_t fu = FU_ALU;
    p.pc = ent[63:32]; p.inst = i; p.opcode = op; p.funct3 = f3; p.funct7 = f7;
    p.rd = i[11:7]; p.rs1 = i[19:15]; p.rs2 = i[24:20];
    case (op)
      7'h37, 7'h17: begin legal = 1; w = 1; p.imm = {i[31:12], 12'h0}; end
      7'h6F: begin legal = 1; w = 1; fu = FU_BR;
        p.imm = sext({11'h0, i[31], i[19:12], i[20], i[30:21], 1'b0}, 21); end
      7'h67: begin legal = f3 == 0; w = 1; fu = FU_BR; p.use_rs1 = 1; p.imm = sext({20'h0, i[31:20]}, 12); end
      7'h63: begin legal = f3 inside {0, 1, 4, 5, 6, 7}; fu = FU_BR; p.use_rs1 = 1; p.use_rs2 = 1;
        p.imm = sext({19'h0, i[31], i[7], i[30:25], i[11:8], 1'b0}, 13); end
      7'h03: begin legal = f3 inside {0, 1, 2, 4, 5}; w = 1; fu = FU_LSU; p.use_rs1 = 1; p.imm = sext({20'h0, i[31:20]}, 12); end
      7'h23: begin legal = f3 inside {0, 1, 2}; fu = FU_LSU; p.use_rs1 = 1; p.use_rs2 = 1;
        p.imm = sext({20'h0, i[31:25], i[11:7]}, 12); end
      7'h13: begin w = 1; p.use_rs1 = 1; p.imm = sext({20'h0, i[31:20]}, 12);
        legal = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 inside {0, 32}) : 1; end
      7'h33: begin w = 1; p.use_rs1 = 1; p.use_rs2 = 1;
        legal = (f7 == 0) || (f7 == 32 && f3 inside {0, 5});
`ifdef DECODE_RVM_EN
        if (f7 == 1) begin legal = 1; fu = FU_MULDIV; end
`endif
      end
      7'h0F: legal = f3 == 0;
      7'h73: legal = i == 32'h00000073 || i == 32'h00100073;
      default: legal = 0;
    endcase
    p.illegal = !legal;
    p.rd_we = legal && w && p.rd != 0;
    p.fu_type = legal ? fu : FU_ALU;
    return p;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [6:0] ops[11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
    logic [31:0] i = $urandom;
    int k = $urandom_range(0, 13);
    if (k < 11) i[6:0] = ops[k];
    if (i[6:0] == 7'h33 || i[6:0] == 7'h13)
      case ($urandom_range(0, 3))
        0: i[31:25] = 7'h00;
        1: i[31:25] = 7'h20;
        2: i[31:25] = 7'h01;
        default: ;
      endcase
    if ($urandom_range(0, 30) == 0) i = 32'h00000073;
    return i;
  endfunction

  // one clock: drive inputs, record the pre-edge dequeue, advance the reference queues
  task automatic cycle(input bit fl, input bit rdy);
    flush = fl; dec_ready = rdy;
    iq_is_empty = iq_q.size() == 0;
    iq_rdata = iq_is_empty ? '0 : iq_q[0];
    #1;
    obs_dq = iq_dequeue;
    exp_dq = iq_q.size() != 0 && !fl && buf_q.size() < 2;
    if (fl) buf_q.delete();
    else begin
      if (buf_q.size() != 0 && rdy) void'(buf_q.pop_front());
      if (exp_dq) buf_q.push_back(iq_q.pop_front());
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    iq_q.push_back({32'h1000, 32'h00100093});
    iq_is_empty = 0; iq_rdata = iq_q[0]; dec_ready = 1;
    #17;
    n_chk++; if (dec_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", dec_valid); else n_pass++;
    n_chk++; if (iq_dequeue !== 1'b0) $display("FAIL reset_dequeue: got %b want 0", iq_dequeue); else n_pass++;
    n_chk++; if (dec_pkt !== '0) $display("FAIL reset_pkt: got %h want 0", dec_pkt); else n_pass++;
    iq_q.delete(); iq_is_empty = 1;
    @(negedge clk); rst_n = 1;
  endtask

  task automatic test_basic();
    iq_q.push_back({32'h1ECEB000, 32'h00500093});
    cycle(0, 1);
    n_chk++; if (obs_dq !== 1'b1) $display("FAIL basic_dequeue: got %b want 1", obs_dq); else n_pass++;
    n_chk++; if (dec_valid !== 1'b1) $display("FAIL basic_valid: got %b want 1", dec_valid); else n_pass++;
    n_chk++; if (dec_pkt.rd !== 5'd1 || dec_pkt.rs1 !== 5'd0) $display("FAIL basic_regs: got rd=%0d rs1=%0d want 1 0", dec_pkt.rd, dec_pkt.rs1); else n_pass++;
    n_chk++; if (dec_pkt.imm !== 32'd5) $display("FAIL basic_imm: got %h want 5", dec_pkt.imm); else n_pass++;
    n_chk++; if (dec_pkt.rd_we !== 1'b1 || dec_pkt.fu_type !== FU_ALU) $display("FAIL basic_ctl: got we=%b fu=%0d want 1 0", dec_pkt.rd_we, dec_pkt.fu_type); else n_pass++;
    cycle(0, 1);
    n_chk++; if (dec_valid !== 1'b0) $display("FAIL basic_drain: got %b want 0", dec_valid); else n_pass++;
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 3; k++) iq_q.push_back({32'h1ECEB000 + 32'(4 * k), 32'h00000013 | (32'(k + 1) << 7)});
    for (int k = 0; k < 4; k++) begin
      cycle(0, 0);
      n_chk++; if (obs_dq !== (k < 2)) $display("FAIL bp_dequeue%0d: got %b want %b", k, obs_dq, k < 2); else n_pass++;
      n_chk++; if (dec_valid !== 1'b1 || dec_pkt.pc !== 32'h1ECEB000) $display("FAIL bp_hold%0d: got v=%b pc=%h want 1 1eceb000", k, dec_valid, dec_pkt.pc); else n_pass++;
    end
    for (int k = 0; k < 3; k++) begin
      n_chk++; if (dec_valid !== 1'b1 || dec_pkt.pc !== 32'h1ECEB000 + 32'(4 * k)) $display("FAIL bp_order%0d: got v=%b pc=%h want pc %h", k, dec_valid, dec_pkt.pc, 32'h1ECEB000 + 32'(4 * k)); else n_pass++;
      cycle(0, 1);
    end
    n_chk++; if (dec_valid !== 1'b0) $display("FAIL bp_empty: got %b want 0", dec_valid); else n_pass++;
  endtask

  task automatic test_branch();
    iq_q.push_back({32'h2000, 32'hFE000EE3});
    cycle(0, 1);
    n_chk++; if (dec_pkt.imm !== 32'hFFFFFFFC) $display("FAIL beq_imm: got %h want fffffffc", dec_pkt.imm); else n_pass++;
    n_chk++; if ({dec_pkt.rd_we, dec_pkt.use_rs1, dec_pkt.use_rs2, dec_pkt.illegal} !== 4'b0110) $display("FAIL beq_flags: got %b want 0110", {dec_pkt.rd_we, dec_pkt.use_rs1, dec_pkt.use_rs2, dec_pkt.illegal}); else n_pass++;
    n_chk++; if (dec_pkt.fu_type !== FU_BR) $display("FAIL beq_fu: got %0d want %0d", dec_pkt.fu_type, FU_BR); else n_pass++;
    cycle(0, 1);
  endtask

  task automatic test_rvm();
    iq_q.push_back({32'h3000, 32'h02208033});
    cycle(0, 1);
`ifdef DECODE_RVM_EN
    n_chk++; if (dec_pkt.fu_type !== FU_MULDIV || dec_pkt.illegal !== 1'b0) $display("FAIL mul_rvm: got fu=%0d ill=%b want 3 0", dec_pkt.fu_type, dec_pkt.illegal); else n_pass++;
`else
    n_chk++; if (dec_pkt.illegal !== 1'b1 || dec_pkt.rd_we !== 1'b0 || dec_pkt.fu_type !== FU_ALU) $display("FAIL mul_norvm: got ill=%b we=%b fu=%0d want 1 0 0", dec_pkt.illegal, dec_pkt.rd_we, dec_pkt.fu_type); else n_pass++;
`endif
    cycle(0, 1);
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++) iq_q.push_back({32'h4000 + 32'(4 * k), 32'h00000013});
    cycle(0, 0);
    cycle(0, 0);
    cycle(1, 1);
    n_chk++; if (obs_dq !== 1'b0) $display("FAIL flush_dequeue: got %b want 0", obs_dq); else n_pass++;
    n_chk++; if (dec_valid !== 1'b0) $display("FAIL flush_valid: got %b want 0", dec_valid); else n_pass++;
    cycle(0, 1);
    n_chk++; if (dec_valid !== 1'b1 || dec_pkt.pc !== 32'h4008) $display("FAIL flush_resume: got v=%b pc=%h want 1 4008", dec_valid, dec_pkt.pc); else n_pass++;
    cycle(0, 1);
  endtask

  task automatic test_async_reset();
    iq_q.push_back({32'h5000, 32'h00100093});
    iq_q.push_back({32'h5004, 32'h00200093});
    cycle(0, 0);
    iq_is_empty = 0; iq_rdata = iq_q[0];
    n_chk++; if (dec_valid !== 1'b1) $display("FAIL arst_pre: got %b want 1", dec_valid); else n_pass++;
    #2 rst_n = 0;
    #1;
    n_chk++; if (dec_valid !== 1'b0 || dec_pkt !== '0) $display("FAIL arst_clear: got v=%b pkt=%h want 0 0", dec_valid, dec_pkt); else n_pass++;
    n_chk++; if (iq_dequeue !== 1'b0) $display("FAIL arst_dequeue: got %b want 0", iq_dequeue); else n_pass++;
    buf_q.delete();
    @(posedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    #1;
    n_chk++; if (iq_dequeue !== 1'b1 || dec_valid !== 1'b0) $display("FAIL arst_release: got dq=%b v=%b want 1 0", iq_dequeue, dec_valid); else n_pass++;
    cycle(0, 1);
    cycle(0, 1);
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 2) != 0 && iq_q.size() < 6) iq_q.push_back({32'($urandom) & 32'hFFFFFFFC, rand_inst()});
      cycle($urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0);
      n_chk++; if (obs_dq !== exp_dq) $display("FAIL rnd_dequeue c%0d: got %b want %b", c, obs_dq, exp_dq); else n_pass++;
      n_chk++; if (dec_valid !== (buf_q.size() != 0)) $display("FAIL rnd_valid c%0d: got %b want %b", c, dec_valid, buf_q.size() != 0); else n_pass++;
      if (buf_q.size() != 0) begin
        e = ref_decode(buf_q[0]);
        n_chk++; if (dec_pkt !== e) $display("FAIL rnd_pkt c%0d: got %h want %h", c, dec_pkt, e); else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_branch();
    test_rvm();
    test_flush();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
